// File: rtl/dft_sequencer_if.sv
// Control/status bundle between the direct-DFT sequencer and its datapath / AXI bridge.
interface dft_sequencer_if #(
  parameter int unsigned AW = 12
);
  logic          data_loaded;
  logic          abort;
  logic [AW-1:0] sample_num;
  logic          load_nCompute;
  logic [AW-1:0] ram_rd_adr;
  logic          cache_wr_en;
  logic [AW-1:0] cache_wr_adr;
  logic [AW-1:0] cache_rd_adr;
  logic [AW-1:0] tw_idx;
  logic          acc_ce;
  logic          acc_clr;
  logic          res_wr_en;
  logic [AW-1:0] res_wr_adr;
  logic          busy;
  logic          calc_end;
  logic          cfg_err;

  modport master (
    input  data_loaded, abort, sample_num,
    output load_nCompute, ram_rd_adr, cache_wr_en, cache_wr_adr, cache_rd_adr,
           tw_idx, acc_ce, acc_clr, res_wr_en, res_wr_adr, busy, calc_end, cfg_err
  );

  modport slave (
    output data_loaded, abort, sample_num,
    input  load_nCompute, ram_rd_adr, cache_wr_en, cache_wr_adr, cache_rd_adr,
           tw_idx, acc_ce, acc_clr, res_wr_en, res_wr_adr, busy, calc_end, cfg_err
  );
endinterface

// File: rtl/dft_sequencer.sv
// Control FSM for the direct-DFT datapath: loads N samples RAM->cache, runs the k/n MAC loop,
// writes each X[k] back to RAM. RD_LAT and MAC_LAT must be at least 1.
module dft_sequencer #(
  parameter int unsigned AW      = 12,
  parameter int unsigned RD_LAT  = 1,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic            clk,
  input  logic            nrst,
  dft_sequencer_if.master bus
);

  localparam int unsigned WAIT_MAX = (RD_LAT > MAC_LAT) ? RD_LAT : MAC_LAT;
  localparam int unsigned CW       = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam int unsigned CWA_W    = RD_LAT * AW;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_MAC   = 3'd3,
    S_DRAIN = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t          r_state, w_state;
  logic [AW-1:0]   r_num, w_num;
  logic [AW-1:0]   r_adr, w_adr;
  logic [AW-1:0]   r_n, w_n;
  logic [AW-1:0]   r_k, w_k;
  logic [AW-1:0]   r_tw, w_tw;
  logic [CW-1:0]   r_wait, w_wait;
  logic            r_rd_vld, w_rd_vld;
  logic            r_mac_vld, w_mac_vld;
  logic            r_mac_first, w_mac_first;
  logic            r_res_wr_en, w_res_wr_en;
  logic            r_calc_end, w_calc_end;
  logic            r_cfg_err, w_cfg_err;
  logic            r_busy, w_busy;
  logic            r_load_ncompute, w_load_ncompute;

  logic [RD_LAT-1:0]  r_cwr_vld_pipe;
  logic [CWA_W-1:0]   r_cwr_adr_pipe;
  logic [MAC_LAT-1:0] r_ce_pipe;
  logic [MAC_LAT-1:0] r_clr_pipe;

  logic [AW-1:0]   w_last;
  logic [AW:0]     w_tw_sum;
  logic [AW-1:0]   w_tw_next;

  // Running twiddle index: one wider than AW so tw+k cannot wrap before the compare with N.
  assign w_last    = r_num - AW'(1);
  assign w_tw_sum  = {1'b0, r_tw} + {1'b0, r_k};
  assign w_tw_next = (w_tw_sum >= {1'b0, r_num}) ? AW'(w_tw_sum - {1'b0, r_num})
                                                 : AW'(w_tw_sum);

  // Next-state and next-output logic
  always_comb begin
    w_state     = r_state;
    w_num       = r_num;
    w_adr       = r_adr;
    w_n         = r_n;
    w_k         = r_k;
    w_tw        = r_tw;
    w_wait      = r_wait;
    w_rd_vld    = 1'b0;
    w_mac_vld   = 1'b0;
    w_mac_first = 1'b0;
    w_res_wr_en = 1'b0;
    w_calc_end  = 1'b0;
    w_cfg_err   = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.data_loaded) begin
          w_num = bus.sample_num;
          if (bus.sample_num < AW'(2)) begin
            w_state    = S_DONE;
            w_calc_end = 1'b1;
            w_cfg_err  = 1'b1;
          end else begin
            w_state  = S_LOAD;
            w_adr    = '0;
            w_rd_vld = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (r_adr == w_last) begin
          w_state = S_FLUSH;
          w_wait  = '0;
        end else begin
          w_adr    = r_adr + AW'(1);
          w_rd_vld = 1'b1;
        end
      end
      S_FLUSH: begin
        if (r_wait == CW'(RD_LAT - 1)) begin
          w_state     = S_MAC;
          w_k         = '0;
          w_n         = '0;
          w_tw        = '0;
          w_mac_vld   = 1'b1;
          w_mac_first = 1'b1;
        end else begin
          w_wait = r_wait + CW'(1);
        end
      end
      S_MAC: begin
        if (r_n == w_last) begin
          w_state = S_DRAIN;
          w_wait  = '0;
        end else begin
          w_n       = r_n + AW'(1);
          w_tw      = w_tw_next;
          w_mac_vld = 1'b1;
        end
      end
      S_DRAIN: begin
        if (r_wait == CW'(MAC_LAT - 1)) begin
          w_state     = S_WRITE;
          w_res_wr_en = 1'b1;
        end else begin
          w_wait = r_wait + CW'(1);
        end
      end
      S_WRITE: begin
        if (r_k == w_last) begin
          w_state    = S_DONE;
          w_calc_end = 1'b1;
        end else begin
          w_state     = S_MAC;
          w_k         = r_k + AW'(1);
          w_n         = '0;
          w_tw        = '0;
          w_mac_vld   = 1'b1;
          w_mac_first = 1'b1;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    // Abort overrides every transition, including a simultaneous start
    if (bus.abort) begin
      w_state     = S_IDLE;
      w_adr       = '0;
      w_n         = '0;
      w_k         = '0;
      w_tw        = '0;
      w_wait      = '0;
      w_rd_vld    = 1'b0;
      w_mac_vld   = 1'b0;
      w_mac_first = 1'b0;
      w_res_wr_en = 1'b0;
      w_calc_end  = 1'b0;
      w_cfg_err   = 1'b0;
    end

    w_busy          = (w_state != S_IDLE);
    w_load_ncompute = !((w_state inside {S_MAC, S_DRAIN, S_WRITE}) ||
                        ((w_state == S_DONE) && !w_cfg_err));
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state         <= S_IDLE;
      r_num           <= '0;
      r_adr           <= '0;
      r_n             <= '0;
      r_k             <= '0;
      r_tw            <= '0;
      r_wait          <= '0;
      r_rd_vld        <= 1'b0;
      r_mac_vld       <= 1'b0;
      r_mac_first     <= 1'b0;
      r_res_wr_en     <= 1'b0;
      r_calc_end      <= 1'b0;
      r_cfg_err       <= 1'b0;
      r_busy          <= 1'b0;
      r_load_ncompute <= 1'b1;
    end else begin
      r_state         <= w_state;
      r_num           <= w_num;
      r_adr           <= w_adr;
      r_n             <= w_n;
      r_k             <= w_k;
      r_tw            <= w_tw;
      r_wait          <= w_wait;
      r_rd_vld        <= w_rd_vld;
      r_mac_vld       <= w_mac_vld;
      r_mac_first     <= w_mac_first;
      r_res_wr_en     <= w_res_wr_en;
      r_calc_end      <= w_calc_end;
      r_cfg_err       <= w_cfg_err;
      r_busy          <= w_busy;
      r_load_ncompute <= w_load_ncompute;
    end
  end

  // Latency-matching pipes: RAM read -> cache write, cache read -> accumulator input
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cwr_vld_pipe <= '0;
      r_cwr_adr_pipe <= '0;
      r_ce_pipe      <= '0;
      r_clr_pipe     <= '0;
    end else if (bus.abort) begin
      r_cwr_vld_pipe <= '0;
      r_cwr_adr_pipe <= '0;
      r_ce_pipe      <= '0;
      r_clr_pipe     <= '0;
    end else begin
      r_cwr_vld_pipe <= (r_cwr_vld_pipe << 1) | RD_LAT'(r_rd_vld);
      r_cwr_adr_pipe <= (r_cwr_adr_pipe << AW) | CWA_W'(r_adr);
      r_ce_pipe      <= (r_ce_pipe << 1) | MAC_LAT'(r_mac_vld);
      r_clr_pipe     <= (r_clr_pipe << 1) | MAC_LAT'(r_mac_vld & r_mac_first);
    end
  end

  assign bus.load_nCompute = r_load_ncompute;
  assign bus.ram_rd_adr    = r_adr;
  assign bus.cache_wr_en   = r_cwr_vld_pipe[RD_LAT-1];
  assign bus.cache_wr_adr  = r_cwr_adr_pipe[CWA_W-1 -: AW];
  assign bus.cache_rd_adr  = r_n;
  assign bus.tw_idx        = r_tw;
  assign bus.acc_ce        = r_ce_pipe[MAC_LAT-1];
  assign bus.acc_clr       = r_clr_pipe[MAC_LAT-1];
  assign bus.res_wr_en     = r_res_wr_en;
  assign bus.res_wr_adr    = r_k;
  assign bus.busy          = r_busy;
  assign bus.calc_end      = r_calc_end;
  assign bus.cfg_err       = r_cfg_err;

endmodule

// File: tb/tb_dft_sequencer.sv
// Randomized self-checking bench for dft_sequencer against a cycle-timeline reference model.
module tb_dft_sequencer;

  localparam int unsigned AW      = 4;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned MAC_LAT = 2;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  dft_sequencer_if #(.AW(AW)) bus ();

  dft_sequencer #(.AW(AW), .RD_LAT(RD_LAT), .MAC_LAT(MAC_LAT)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Index (cycles after the start edge) of the calc_end cycle
  function automatic int last_cycle(input int num);
    return (num < 2) ? 0 : num + int'(RD_LAT) + num * (num + int'(MAC_LAT) + 1);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".busy"},          32'(bus.busy),          32'd0);
    check({tag, ".calc_end"},      32'(bus.calc_end),      32'd0);
    check({tag, ".acc_ce"},        32'(bus.acc_ce),        32'd0);
    check({tag, ".res_wr_en"},     32'(bus.res_wr_en),     32'd0);
    check({tag, ".cache_wr_en"},   32'(bus.cache_wr_en),   32'd0);
    check({tag, ".load_nCompute"}, 32'(bus.load_nCompute), 32'd1);
  endtask

  task automatic check_rst(input string tag);
    check_idle(tag);
    check({tag, ".cfg_err"},      32'(bus.cfg_err),      32'd0);
    check({tag, ".acc_clr"},      32'(bus.acc_clr),      32'd0);
    check({tag, ".ram_rd_adr"},   32'(bus.ram_rd_adr),   32'd0);
    check({tag, ".cache_wr_adr"}, 32'(bus.cache_wr_adr), 32'd0);
    check({tag, ".cache_rd_adr"}, 32'(bus.cache_rd_adr), 32'd0);
    check({tag, ".tw_idx"},       32'(bus.tw_idx),       32'd0);
    check({tag, ".res_wr_adr"},   32'(bus.res_wr_adr),   32'd0);
  endtask

  // One transform; abort_c / rst_c / junk_c are cycle indices (or -1) for abort, reset, ignored start
  task automatic run_xfer(input int num, input int abort_c, input int rst_c, input int junk_c);
    int last, m0, blen, stop, calc_seen, ce_cnt, clr_cnt, wr_tot, k, p;
    int wr_cnt [16];
    logic e_cwr, e_ce, e_clr, e_wr;
    last      = last_cycle(num);
    m0        = num + int'(RD_LAT);
    blen      = num + int'(MAC_LAT) + 1;
    calc_seen = -1;
    ce_cnt    = 0;
    clr_cnt   = 0;
    wr_tot    = 0;
    foreach (wr_cnt[i]) wr_cnt[i] = 0;
    stop = (abort_c >= 0) ? abort_c + 3 : ((rst_c >= 0) ? rst_c : last + 1);

    @(negedge clk);
    bus.sample_num  = AW'(num);
    bus.data_loaded = 1'b1;
    @(posedge clk);
    for (int c = 0; c <= stop; c++) begin
      @(negedge clk);
      bus.data_loaded = (c == junk_c);
      bus.abort       = (c == abort_c);
      bus.sample_num  = AW'($urandom);
      if (bus.calc_end && calc_seen < 0) calc_seen = c;
      if (bus.acc_ce) ce_cnt++;
      if (bus.acc_ce && bus.acc_clr) clr_cnt++;
      if (bus.res_wr_en) begin
        wr_cnt[bus.res_wr_adr]++;
        wr_tot++;
      end
      if (abort_c >= 0 && c > abort_c) begin
        check_idle("after_abort");
      end else begin
        check("busy",     32'(bus.busy),     32'(c <= last));
        check("calc_end", 32'(bus.calc_end), 32'(c == last));
        check("cfg_err",  32'(bus.cfg_err),  32'((c == last) && (num < 2)));
        check("load_nCompute", 32'(bus.load_nCompute),
              32'(!((num >= 2) && (c >= m0) && (c <= last))));
        if (num >= 2 && c < num) check("ram_rd_adr", 32'(bus.ram_rd_adr), 32'(c));
        e_cwr = (num >= 2) && (c >= int'(RD_LAT)) && (c < num + int'(RD_LAT));
        check("cache_wr_en", 32'(bus.cache_wr_en), 32'(e_cwr));
        if (e_cwr) check("cache_wr_adr", 32'(bus.cache_wr_adr), 32'(c - int'(RD_LAT)));
        e_ce = 1'b0; e_clr = 1'b0; e_wr = 1'b0; k = 0;
        if (num >= 2 && c >= m0 && c < last) begin
          k = (c - m0) / blen;
          p = (c - m0) % blen;
          if (p < num) begin
            check("cache_rd_adr", 32'(bus.cache_rd_adr), 32'(p));
            check("tw_idx",       32'(bus.tw_idx),       32'((p * k) % num));
          end
          e_ce  = (p >= int'(MAC_LAT)) && (p < num + int'(MAC_LAT));
          e_clr = (p == int'(MAC_LAT));
          e_wr  = (p == num + int'(MAC_LAT));
        end
        check("acc_ce", 32'(bus.acc_ce), 32'(e_ce));
        if (e_ce) check("acc_clr", 32'(bus.acc_clr), 32'(e_clr));
        check("res_wr_en", 32'(bus.res_wr_en), 32'(e_wr));
        if (e_wr) check("res_wr_adr", 32'(bus.res_wr_adr), 32'(k));
      end
      if (c == rst_c) begin
        nrst = 1'b0;
        #1;
        check_rst("async_rst");
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
        check_idle("rst_release");
      end
    end
    bus.data_loaded = 1'b0;
    bus.abort       = 1'b0;

    if (abort_c >= 0) begin
      check("abort_no_calc_end", 32'(calc_seen), 32'hFFFF_FFFF);
    end else if (rst_c < 0) begin
      check("cycle_count", 32'(calc_seen + 2),
            32'((num < 2) ? 2 : 1 + num + int'(RD_LAT) + num * (num + int'(MAC_LAT) + 1) + 1));
      check("acc_ce_total",  32'(ce_cnt),  32'((num < 2) ? 0 : num * num));
      check("acc_clr_total", 32'(clr_cnt), 32'((num < 2) ? 0 : num));
      check("res_wr_total",  32'(wr_tot),  32'((num < 2) ? 0 : num));
      for (int i = 0; i < num && num >= 2; i++) check("res_wr_once", 32'(wr_cnt[i]), 32'd1);
    end
  endtask

  initial begin
    int num, last, ab, junk;
    bus.data_loaded = 1'b0;
    bus.abort       = 1'b0;
    bus.sample_num  = '0;
    nrst            = 1'b0;
    repeat (3) @(negedge clk);
    check_rst("reset");
    nrst = 1'b1;
    @(negedge clk);
    check_idle("idle0");

    run_xfer(4, -1, -1, 2);
    run_xfer(5, -1, -1, -1);
    run_xfer(1, -1, -1, -1);
    run_xfer(0, -1, -1, 0);
    run_xfer(2, -1, -1, -1);
    // abort inside the k=2 MAC window, then a clean run
    run_xfer(4, (4 + int'(RD_LAT)) + 2 * (4 + int'(MAC_LAT) + 1) + int'($urandom_range(0, 3)), -1, 1);
    run_xfer(4, -1, -1, -1);

    @(negedge clk);
    bus.sample_num  = AW'(4);
    bus.data_loaded = 1'b1;
    bus.abort       = 1'b1;
    @(negedge clk);
    bus.data_loaded = 1'b0;
    bus.abort       = 1'b0;
    check_idle("abort_with_start");
    @(negedge clk);
    check_idle("abort_with_start2");

    // reset in the first DRAIN cycle of k=1, then a clean run
    run_xfer(3, -1, (3 + int'(RD_LAT)) + (3 + int'(MAC_LAT) + 1) + 3, -1);
    run_xfer(3, -1, -1, -1);
    run_xfer(15, -1, -1, 7);

    repeat (8) begin
      num  = int'($urandom_range(0, 15));
      last = last_cycle(num);
      ab   = (last > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, last - 1)) : -1;
      junk = int'($urandom_range(0, last));
      if (ab >= 0 && junk >= ab) junk = -1;
      run_xfer(num, ab, -1, junk);
    end

    @(negedge clk);
    check_idle("final");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
